// File: rtl/diffeq_seq_controller_if.sv
// Handshake and control bundle between the operand/datapath side and the solver sequencer.
// slave: the controller; master: the environment driving operands and datapath status.
interface diffeq_seq_controller_if #(
  parameter int NUM_OPERANDS = 4,
  parameter int NUM_STAGES   = 4,
  parameter int ITER_W       = 8
);
  localparam int SEL_W = (NUM_OPERANDS > 1) ? $clog2(NUM_OPERANDS) : 1;
  localparam int STG_W = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;

  logic                    start;
  logic                    op_valid;
  logic [SEL_W-1:0]        op_sel;
  logic                    ready;
  logic                    compute_done;
  logic                    continue_while;
  logic                    result_ack;
  logic [NUM_OPERANDS-1:0] load_en;
  logic [1:0]              state;
  logic [STG_W-1:0]        stage;
  logic                    stage_start;
  logic [ITER_W-1:0]       iter_count;
  logic                    valid;
  logic                    overflow;
  logic                    timeout;

  modport master (
    output start, op_valid, op_sel, ready, compute_done, continue_while, result_ack,
    input  load_en, state, stage, stage_start, iter_count, valid, overflow, timeout
  );

  modport slave (
    input  start, op_valid, op_sel, ready, compute_done, continue_while, result_ack,
    output load_en, state, stage, stage_start, iter_count, valid, overflow, timeout
  );
endinterface

// File: rtl/diffeq_seq_controller.sv
// Sequencer for the differential-equation datapath: operand load, N-stage compute loop, bounded iterations.
// Optional per-stage watchdog enabled by defining DIFFEQ_WATCHDOG_EN.
module diffeq_seq_controller #(
  parameter int NUM_OPERANDS = 4,
  parameter int NUM_STAGES   = 4,
  parameter int MAX_ITER     = 16,
  parameter int ITER_W       = 8,
  parameter int WDOG_CYCLES  = 64
) (
  input logic                    clk,
  input logic                    reset_n,
  diffeq_seq_controller_if.slave bus
);
  localparam int SEL_W = (NUM_OPERANDS > 1) ? $clog2(NUM_OPERANDS) : 1;
  localparam int STG_W = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_READ    = 2'd1,
    S_COMPUTE = 2'd2,
    S_DONE    = 2'd3
  } state_e;

  state_e                  state_q, state_d;
  logic [NUM_OPERANDS-1:0] load_en_q, load_en_d;
  logic [STG_W-1:0]        stage_q, stage_d;
  logic                    stage_start_q, stage_start_d;
  logic [ITER_W-1:0]       iter_q, iter_d;
  logic                    valid_q, valid_d;
  logic                    ovf_q, ovf_d;
  logic                    tmo_q, tmo_d;

  logic              last_stage;
  logic [ITER_W:0]   iter_inc;
  logic              iter_more;
  logic              op_in_range;
  logic              wdog_fire;

  assign last_stage  = (stage_q == STG_W'(NUM_STAGES - 1));
  assign iter_inc    = {1'b0, iter_q} + (ITER_W+1)'(1);
  assign iter_more   = (iter_inc < (ITER_W+1)'(MAX_ITER));
  assign op_in_range = ({1'b0, bus.op_sel} < (SEL_W+1)'(NUM_OPERANDS));

`ifdef DIFFEQ_WATCHDOG_EN
  localparam int WD_W = $clog2(WDOG_CYCLES + 1);
  logic [WD_W-1:0] wdog_q, wdog_d;

  // Expiry loses to a compute_done in the same cycle.
  assign wdog_fire = (state_q == S_COMPUTE) && !bus.compute_done &&
                     (wdog_q == WD_W'(WDOG_CYCLES - 1));

  always_comb begin
    wdog_d = wdog_q;
    if (stage_start_d)               wdog_d = '0;
    else if (state_q == S_COMPUTE)   wdog_d = wdog_q + WD_W'(1);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) wdog_q <= '0;
    else          wdog_q <= wdog_d;
  end
`else
  logic unused_wdog_cfg;
  assign unused_wdog_cfg = (WDOG_CYCLES != 0);
  assign wdog_fire       = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= S_IDLE;
      load_en_q     <= '0;
      stage_q       <= '0;
      stage_start_q <= 1'b0;
      iter_q        <= '0;
      valid_q       <= 1'b0;
      ovf_q         <= 1'b0;
      tmo_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      load_en_q     <= load_en_d;
      stage_q       <= stage_d;
      stage_start_q <= stage_start_d;
      iter_q        <= iter_d;
      valid_q       <= valid_d;
      ovf_q         <= ovf_d;
      tmo_q         <= tmo_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    if (bus.start) state_d = S_READ;
      S_READ:    if (bus.ready) state_d = S_COMPUTE;
      S_COMPUTE: begin
        if (bus.compute_done) begin
          if (last_stage && !(bus.continue_while && iter_more)) state_d = S_DONE;
        end else if (wdog_fire) begin
          state_d = S_DONE;
        end
      end
      S_DONE:    if (bus.result_ack) state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  always_comb begin
    load_en_d     = '0;
    stage_d       = stage_q;
    stage_start_d = 1'b0;
    iter_d        = iter_q;
    valid_d       = valid_q;
    ovf_d         = ovf_q;
    tmo_d         = tmo_q;
    case (state_q)
      S_READ: begin
        // A load request coinciding with ready still gets its pulse.
        if (bus.op_valid && op_in_range) load_en_d = NUM_OPERANDS'(1) << bus.op_sel;
        if (bus.ready) begin
          stage_d       = '0;
          stage_start_d = 1'b1;
          iter_d        = '0;
          valid_d       = 1'b0;
          ovf_d         = 1'b0;
          tmo_d         = 1'b0;
        end
      end
      S_COMPUTE: begin
        if (bus.compute_done) begin
          if (!last_stage) begin
            stage_d       = stage_q + STG_W'(1);
            stage_start_d = 1'b1;
          end else begin
            iter_d = iter_inc[ITER_W-1:0];
            if (bus.continue_while && iter_more) begin
              stage_d       = '0;
              stage_start_d = 1'b1;
            end else begin
              // Still wanting to loop here means the limit forced the exit.
              valid_d = 1'b1;
              ovf_d   = bus.continue_while;
            end
          end
        end else if (wdog_fire) begin
          valid_d = 1'b1;
          tmo_d   = 1'b1;
        end
      end
      S_DONE:  if (bus.result_ack) valid_d = 1'b0;
      default: ;
    endcase
  end

  assign bus.load_en     = load_en_q;
  assign bus.state       = state_q;
  assign bus.stage       = stage_q;
  assign bus.stage_start = stage_start_q;
  assign bus.iter_count  = iter_q;
  assign bus.valid       = valid_q;
  assign bus.overflow    = ovf_q;
  assign bus.timeout     = tmo_q;
endmodule

// File: tb/tb_diffeq_seq_controller.sv
// Randomized self-checking bench for diffeq_seq_controller (5 operands, 4 stages, MAX_ITER=5).
module tb_diffeq_seq_controller;
  localparam int NO = 5;
  localparam int NS = 4;
  localparam int MI = 5;
  localparam int IW = 8;
  localparam int WD = 8;

  logic clk;
  logic reset_n;
  int   n_chk;
  int   n_pass;

  diffeq_seq_controller_if #(.NUM_OPERANDS(NO), .NUM_STAGES(NS), .ITER_W(IW)) bus ();

  diffeq_seq_controller #(
    .NUM_OPERANDS(NO), .NUM_STAGES(NS), .MAX_ITER(MI), .ITER_W(IW), .WDOG_CYCLES(WD)
  ) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish, passed %0d of %0d", n_pass, n_chk);
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.start = 0; bus.op_valid = 0; bus.op_sel = '0; bus.ready = 0;
    bus.compute_done = 0; bus.continue_while = 0; bus.result_ack = 0;
  endtask

  task automatic enter_compute();
    bus.start = 1; step(); bus.start = 0;
    n_chk++;
    if (bus.state !== 2'd1) $display("FAIL enter_read: state=%0d expected 1", bus.state);
    else n_pass++;
    bus.ready = 1; step(); bus.ready = 0;
    n_chk++;
    if ({bus.state, bus.stage, bus.stage_start, bus.iter_count, bus.overflow, bus.timeout, bus.valid}
        !== {2'd2, 2'd0, 1'b1, 8'd0, 1'b0, 1'b0, 1'b0})
      $display("FAIL enter_compute: state=%0d stage=%0d ss=%b iter=%0d ovf=%b tmo=%b valid=%b expected 2/0/1/0/0/0/0",
               bus.state, bus.stage, bus.stage_start, bus.iter_count, bus.overflow, bus.timeout, bus.valid);
    else n_pass++;
  endtask

  // Finish the current iteration from stage `from` with continue_while=0, then acknowledge.
  task automatic finish_and_ack(input int from);
    for (int s = from; s < NS; s++) begin
      bus.compute_done = 1; bus.continue_while = 0; step();
    end
    bus.compute_done = 0;
    n_chk++;
    if (bus.state !== 2'd3 || bus.valid !== 1'b1)
      $display("FAIL finish_done: state=%0d valid=%b expected 3/1", bus.state, bus.valid);
    else n_pass++;
    bus.result_ack = 1; step(); bus.result_ack = 0;
    n_chk++;
    if (bus.state !== 2'd0 || bus.valid !== 1'b0)
      $display("FAIL finish_ack: state=%0d valid=%b expected 0/0", bus.state, bus.valid);
    else n_pass++;
  endtask

  task automatic test_reset();
    reset_n = 0;
    clear_inputs();
    step(); step();
    n_chk++;
    if ({bus.load_en, bus.state, bus.stage, bus.stage_start, bus.iter_count, bus.valid, bus.overflow, bus.timeout} !== '0)
      $display("FAIL reset_outputs: state=%0d load_en=%b valid=%b expected all zero", bus.state, bus.load_en, bus.valid);
    else n_pass++;
    #2 reset_n = 1;
    step();
    n_chk++;
    if (bus.state !== 2'd0) $display("FAIL reset_release: state=%0d expected 0", bus.state);
    else n_pass++;
  endtask

  task automatic test_reset_mid_compute();
    enter_compute();
    bus.compute_done = 1; step(); step(); bus.compute_done = 0;
    n_chk++;
    if (bus.state !== 2'd2 || bus.stage !== 2'd2)
      $display("FAIL midreset_setup: state=%0d stage=%0d expected 2/2", bus.state, bus.stage);
    else n_pass++;
    #2 reset_n = 0;
    #1;
    n_chk++;
    if ({bus.load_en, bus.state, bus.stage, bus.stage_start, bus.iter_count, bus.valid, bus.overflow, bus.timeout} !== '0)
      $display("FAIL midreset_async: state=%0d stage=%0d expected 0/0 before clock edge", bus.state, bus.stage);
    else n_pass++;
    #1 reset_n = 1;
    step();
    n_chk++;
    if (bus.state !== 2'd0) $display("FAIL midreset_after: state=%0d expected 0", bus.state);
    else n_pass++;
  endtask

  task automatic test_read();
    logic [NO-1:0] exp_le;
    int v, sel;
    bus.start = 1; step(); bus.start = 0;
    n_chk++;
    if (bus.state !== 2'd1) $display("FAIL read_enter: state=%0d expected 1", bus.state);
    else n_pass++;
    for (int i = 0; i < 4; i++) begin
      bus.op_valid = 1; bus.op_sel = 3'(i); step();
      exp_le = '0; exp_le[i] = 1'b1;
      n_chk++;
      if (bus.load_en !== exp_le) $display("FAIL read_seq%0d: load_en=%b expected %b", i, bus.load_en, exp_le);
      else n_pass++;
    end
    bus.op_sel = 3'd5; step();
    n_chk++;
    if (bus.load_en !== '0) $display("FAIL read_oob: load_en=%b expected 0", bus.load_en);
    else n_pass++;
    for (int i = 0; i < 16; i++) begin
      v = $urandom_range(0, 1); sel = $urandom_range(0, 7);
      bus.op_valid = v[0]; bus.op_sel = 3'(sel); step();
      exp_le = '0;
      if (v == 1 && sel < NO) exp_le[sel] = 1'b1;
      n_chk++;
      if (bus.load_en !== exp_le || bus.state !== 2'd1)
        $display("FAIL read_rand: v=%0d sel=%0d load_en=%b state=%0d expected %b/1", v, sel, bus.load_en, bus.state, exp_le);
      else n_pass++;
    end
    bus.op_valid = 1; bus.op_sel = 3'd2; bus.ready = 1; step();
    bus.op_valid = 0; bus.ready = 0;
    n_chk++;
    if (bus.state !== 2'd2 || bus.load_en !== 5'b00100)
      $display("FAIL read_ready_same: state=%0d load_en=%b expected 2/00100", bus.state, bus.load_en);
    else n_pass++;
    step();
    n_chk++;
    if (bus.load_en !== '0 || bus.stage_start !== 1'b0 || bus.stage !== 2'd0)
      $display("FAIL read_after: load_en=%b ss=%b stage=%0d expected 0/0/0", bus.load_en, bus.stage_start, bus.stage);
    else n_pass++;
    finish_and_ack(0);
  endtask

  // Reference: continue_while=1 on the last stage of the first n_cont iterations, 0 afterwards.
  task automatic run_solve(input int n_cont, input string tag);
    int exp_iter, ss_cnt, w, hold;
    bit exp_ovf;
    exp_iter = (n_cont < MI) ? n_cont + 1 : MI;
    exp_ovf  = (n_cont >= MI);
    ss_cnt   = 0;
    enter_compute();
    for (int it = 0; it < exp_iter; it++) begin
      for (int s = 0; s < NS; s++) begin
        n_chk++;
        if (bus.state !== 2'd2 || bus.stage !== 2'(s) || bus.stage_start !== 1'b1)
          $display("FAIL %s_entry: it=%0d state=%0d stage=%0d ss=%b expected 2/%0d/1", tag, it, bus.state, bus.stage, bus.stage_start, s);
        else n_pass++;
        ss_cnt += int'(bus.stage_start);
        w = $urandom_range(0, 3);
        for (int k = 0; k < w; k++) begin
          bus.compute_done = 0; bus.continue_while = 1'($urandom); step();
          n_chk++;
          if (bus.state !== 2'd2 || bus.stage !== 2'(s) || bus.stage_start !== 1'b0)
            $display("FAIL %s_wait: stage=%0d ss=%b expected %0d/0", tag, bus.stage, bus.stage_start, s);
          else n_pass++;
          ss_cnt += int'(bus.stage_start);
        end
        bus.compute_done = 1;
        bus.continue_while = (s == NS - 1) ? (it < n_cont) : 1'($urandom);
        step();
        bus.compute_done = 0; bus.continue_while = 0;
      end
    end
    n_chk++;
    if ({bus.state, bus.valid, bus.iter_count, bus.overflow, bus.timeout, bus.stage_start}
        !== {2'd3, 1'b1, 8'(exp_iter), exp_ovf, 1'b0, 1'b0})
      $display("FAIL %s_done: state=%0d valid=%b iter=%0d ovf=%b tmo=%b expected 3/1/%0d/%b/0",
               tag, bus.state, bus.valid, bus.iter_count, bus.overflow, bus.timeout, exp_iter, exp_ovf);
    else n_pass++;
    n_chk++;
    if (ss_cnt !== exp_iter * NS)
      $display("FAIL %s_stage_starts: count=%0d expected %0d", tag, ss_cnt, exp_iter * NS);
    else n_pass++;
    hold = $urandom_range(1, 3);
    for (int k = 0; k < hold; k++) begin
      bus.start = 1'($urandom); step();
      n_chk++;
      if (bus.state !== 2'd3 || bus.valid !== 1'b1 || bus.iter_count !== 8'(exp_iter))
        $display("FAIL %s_hold: state=%0d valid=%b iter=%0d expected 3/1/%0d", tag, bus.state, bus.valid, bus.iter_count, exp_iter);
      else n_pass++;
    end
    bus.start = 0; bus.result_ack = 1; step(); bus.result_ack = 0;
    n_chk++;
    if (bus.state !== 2'd0 || bus.valid !== 1'b0 || bus.iter_count !== 8'(exp_iter) || bus.overflow !== exp_ovf)
      $display("FAIL %s_ack: state=%0d valid=%b iter=%0d ovf=%b expected 0/0/%0d/%b",
               tag, bus.state, bus.valid, bus.iter_count, bus.overflow, exp_iter, exp_ovf);
    else n_pass++;
  endtask

  task automatic test_single_iter(); run_solve(0, "single"); endtask
  task automatic test_loop();        run_solve(3, "loop");   endtask
  task automatic test_limit();       run_solve(MI + 2, "limit"); endtask

  task automatic test_random();
    for (int r = 0; r < 6; r++) run_solve($urandom_range(0, 7), "rand");
  endtask

  task automatic test_watchdog();
    enter_compute();
    bus.compute_done = 1; step(); bus.compute_done = 0;
`ifdef DIFFEQ_WATCHDOG_EN
    for (int k = 0; k < WD - 1; k++) step();
    n_chk++;
    if (bus.state !== 2'd2 || bus.stage !== 2'd1)
      $display("FAIL wdog_before: state=%0d stage=%0d expected 2/1", bus.state, bus.stage);
    else n_pass++;
    step();
    n_chk++;
    if ({bus.state, bus.timeout, bus.valid, bus.iter_count, bus.overflow} !== {2'd3, 1'b1, 1'b1, 8'd0, 1'b0})
      $display("FAIL wdog_fire: state=%0d tmo=%b valid=%b iter=%0d expected 3/1/1/0", bus.state, bus.timeout, bus.valid, bus.iter_count);
    else n_pass++;
    bus.result_ack = 1; step(); bus.result_ack = 0;
    n_chk++;
    if (bus.state !== 2'd0 || bus.timeout !== 1'b1)
      $display("FAIL wdog_ack: state=%0d tmo=%b expected 0/1", bus.state, bus.timeout);
    else n_pass++;
    enter_compute();
    bus.compute_done = 1; step(); bus.compute_done = 0;
    for (int k = 0; k < WD - 1; k++) step();
    bus.compute_done = 1; step(); bus.compute_done = 0;
    n_chk++;
    if (bus.state !== 2'd2 || bus.stage !== 2'd2 || bus.timeout !== 1'b0)
      $display("FAIL wdog_race: state=%0d stage=%0d tmo=%b expected 2/2/0", bus.state, bus.stage, bus.timeout);
    else n_pass++;
    finish_and_ack(2);
`else
    for (int k = 0; k < 100; k++) step();
    n_chk++;
    if (bus.state !== 2'd2 || bus.stage !== 2'd1 || bus.timeout !== 1'b0 || bus.valid !== 1'b0)
      $display("FAIL nowdog_stay: state=%0d stage=%0d tmo=%b valid=%b expected 2/1/0/0", bus.state, bus.stage, bus.timeout, bus.valid);
    else n_pass++;
    finish_and_ack(1);
`endif
  endtask

  initial begin
    n_chk = 0;
    n_pass = 0;
    test_reset();
    test_reset_mid_compute();
    test_read();
    test_single_iter();
    test_loop();
    test_limit();
    test_random();
    test_watchdog();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
